// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector: FSM encoding,
// default sizing and the configuration loaded at reset.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_PATTERN = 'b1011;
  localparam int DEF_LEN     = 4;
  localparam bit DEF_OVERLAP = 1'b1;
  localparam int DEF_LIMIT   = 0;

endpackage

// File: rtl/seq_det_window.sv
// Serial history window: shifts accepted bits, tracks how many are valid and
// compares the newest len bits (including the incoming one) against the pattern.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               clr_fill,
  output logic               match
);

  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;

  logic [MAX_LEN-1:0] w_cand;
  logic [MAX_LEN:0]   w_one;
  logic [MAX_LEN:0]   w_mask_full;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_fill_ok;

  assign w_cand      = {r_hist, din};
  assign w_one       = (MAX_LEN+1)'(1);
  assign w_mask_full = (w_one << len) - w_one;
  assign w_mask      = w_mask_full[MAX_LEN-1:0];
  // The incoming bit counts toward the window, hence fill+1.
  assign w_fill_ok   = ({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, len};
  assign match       = accept && w_fill_ok && (((w_cand ^ pattern) & w_mask) == '0);

  always_ff @(posedge clk) begin
    if (rst || clr_fill) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (accept) begin
      r_hist <= w_cand[MAX_LEN-2:0];
      if (r_fill != LEN_W'(MAX_LEN))
        r_fill <= r_fill + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial pattern detector: configuration registers,
// IDLE/RUN/DONE sequencing, input handshake and match counting.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_limit,
  input  logic               start,
  input  logic               abort,
  input  logic               din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output state_t             dbg_state
);

  // Handshake: a bit transfers in any cycle where din_valid && din_ready;
  // din_ready is high only in RUN and drops in the same cycle abort is seen.

  state_t             r_state, w_next;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_limit;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cfg_err;

  logic w_accept, w_match, w_limit_hit, w_enter_run, w_clr_fill;
  logic w_len_ok, w_cfg_ok, w_cfg_bad;

  assign din_ready   = (r_state == ST_RUN) && !abort;
  assign w_accept    = din_valid && din_ready;
  assign w_limit_hit = w_match && (r_limit != '0) &&
                       (({1'b0, r_cnt} + (CNT_W+1)'(1)) == {1'b0, r_limit});
  assign w_enter_run = (w_next == ST_RUN) && (r_state != ST_RUN);
  assign w_clr_fill  = w_enter_run || (w_match && !r_overlap);

  assign w_len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign w_cfg_ok  = cfg_we && (r_state != ST_RUN) && w_len_ok;
  assign w_cfg_bad = cfg_we && !w_cfg_ok;

  seq_det_window #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_window (
    .clk      (clk),
    .rst      (rst),
    .accept   (w_accept),
    .din      (din),
    .pattern  (r_pattern),
    .len      (r_len),
    .clr_fill (w_clr_fill),
    .match    (w_match)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (!abort && start) w_next = ST_RUN;
      ST_RUN: begin
        if (abort)            w_next = ST_IDLE;
        else if (w_limit_hit) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (abort)      w_next = ST_IDLE;
        else if (start) w_next = ST_RUN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pattern <= MAX_LEN'(DEF_PATTERN);
      r_len     <= LEN_W'(DEF_LEN);
      r_overlap <= DEF_OVERLAP;
      r_limit   <= CNT_W'(DEF_LIMIT);
      r_cnt     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cfg_err <= w_cfg_bad;
      if (w_cfg_ok) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_limit   <= cfg_limit;
      end
      if (w_enter_run)
        r_cnt <= '0;
      else if (w_match && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign y         = w_match;
  assign match_cnt = r_cnt;
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign cfg_err   = r_cfg_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: runs hand-worked bit streams through
// several configurations and checks y, match_cnt, status and cfg_err.
module tb_seq_det_ctrl;
  import seq_det_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_limit;
  logic       start, abort, din, din_valid;
  logic       din_ready, y, busy, done, cfg_err;
  logic [7:0] match_cnt;
  state_t     dbg_state;

  int n_vec = 0;
  int n_err = 0;

  seq_det_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
    .start(start), .abort(abort), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .y(y), .match_cnt(match_cnt), .busy(busy),
    .done(done), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len,
                           input logic ov, input logic [7:0] lim);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_limit = lim;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort;
    abort = 1'b1;
    @(negedge clk);
    check("ready_in_abort", din_ready, 0);
    tick();
    abort = 1'b0;
  endtask

  // bits[n-1] is sent first; exp_y uses the same ordering.
  task automatic send_stream(input string tag, input logic [15:0] bits,
                             input int n, input logic [15:0] exp_y);
    for (int i = n - 1; i >= 0; i--) begin
      din = bits[i]; din_valid = 1'b1;
      @(negedge clk);
      check($sformatf("%s_y_bit%0d", tag, n - i), y, exp_y[i]);
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    din_valid = 1'b0; din = 1'b1;
    @(negedge clk);
    check(tag, y, 0);
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, din_ready, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_cnt"}, match_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, cfg_err, 0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_limit = '0; start = 1'b0; abort = 1'b0; din = 1'b0; din_valid = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b0; din_valid = 1'b0;
    tick();
    check_outputs_zero("post_reset");

    // 1: default 1011, overlapping
    do_start();
    check("t1_busy", busy, 1);
    check("t1_ready", din_ready, 1);
    send_stream("t1", 16'b01011011, 8, 16'b00001001);
    check("t1_cnt", match_cnt, 2);
    do_abort();
    check("t1_cnt_hold_idle", match_cnt, 2);

    // 2: non-overlapping
    cfg_write(8'b1011, 4'd4, 1'b0, 8'd0);
    check("t2_no_err", cfg_err, 0);
    do_start();
    check("t2_cnt_cleared", match_cnt, 0);
    send_stream("t2", 16'b01011011, 8, 16'b00001000);
    check("t2_cnt", match_cnt, 1);
    do_abort();

    // 3: limit of one match
    cfg_write(8'b1011, 4'd4, 1'b1, 8'd1);
    do_start();
    send_stream("t3a", 16'b01011, 5, 16'b00001);
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    check("t3_ready", din_ready, 0);
    send_stream("t3b", 16'b011, 3, 16'b000);
    check("t3_cnt", match_cnt, 1);
    do_start();
    check("t3_restart_busy", busy, 1);
    check("t3_restart_cnt", match_cnt, 0);
    check("t3_restart_done", done, 0);
    do_abort();
    check("t3_abort_idle", dbg_state, ST_IDLE);

    // 4: pattern 111, len 3
    cfg_write(8'b111, 4'd3, 1'b1, 8'd0);
    do_start();
    send_stream("t4a", 16'b11111, 5, 16'b00111);
    check("t4a_cnt", match_cnt, 3);
    do_abort();
    cfg_write(8'b111, 4'd3, 1'b0, 8'd0);
    do_start();
    send_stream("t4b", 16'b11111, 5, 16'b00100);
    check("t4b_cnt", match_cnt, 1);
    do_abort();

    // 5: rejected writes
    cfg_write(8'b111, 4'd3, 1'b1, 8'd0);
    do_start();
    send_stream("t5a", 16'b11, 2, 16'b00);
    cfg_we = 1'b1; cfg_pattern = 8'b1011; cfg_len = 4'd4; cfg_overlap = 1'b0; cfg_limit = 8'd1;
    @(negedge clk);
    check("t5_err_same_cycle", cfg_err, 0);
    tick();
    cfg_we = 1'b0;
    check("t5_err_run", cfg_err, 1);
    tick();
    check("t5_err_clears", cfg_err, 0);
    send_stream("t5b", 16'b111, 3, 16'b111);
    check("t5_busy", busy, 1);
    do_abort();
    cfg_write(8'b1011, 4'd0, 1'b0, 8'd0);
    check("t5_err_len0", cfg_err, 1);
    cfg_write(8'b1011, 4'd9, 1'b0, 8'd0);
    check("t5_err_len9", cfg_err, 1);
    do_start();
    check("t5_err_after_start", cfg_err, 0);
    send_stream("t5c", 16'b11111, 5, 16'b00111);
    do_abort();

    // 6: gaps, abort mid-pattern, reset in RUN
    cfg_write(8'b1011, 4'd4, 1'b1, 8'd0);
    do_start();
    send_stream("t6a", 16'b1, 1, 16'b0);
    idle_cycle("t6_gap1");
    send_stream("t6b", 16'b0, 1, 16'b0);
    idle_cycle("t6_gap2");
    idle_cycle("t6_gap3");
    send_stream("t6c", 16'b11, 2, 16'b01);
    check("t6_cnt", match_cnt, 1);
    send_stream("t6d", 16'b101, 3, 16'b000);
    do_abort();
    check("t6_abort_busy", busy, 0);
    check("t6_abort_ready", din_ready, 0);
    din = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    check("t6_idle_y", y, 0);
    tick();
    din_valid = 1'b0;

    cfg_write(8'b111, 4'd3, 1'b0, 8'd5);
    do_start();
    send_stream("t6e", 16'b11, 2, 16'b00);
    rst = 1'b1; din = 1'b1; din_valid = 1'b1;
    tick();
    check_outputs_zero("t6_rst");
    rst = 1'b0; din_valid = 1'b0;
    tick();
    do_start();
    send_stream("t6f", 16'b0101101, 7, 16'b0000100);
    check("t6f_cnt", match_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
